// File: rtl/s2p_frame_shifter_if.sv
// -----------------------------------------------------------------------------
// s2p_frame_shifter_if
//   Frame handshake between the serial-to-parallel frame shifter (master) and
//   the parallel datapath that consumes completed frames (slave).
//
//   FRAME_Q    master -> slave  WIDTH  last completed frame
//   FRAME_VLD  master -> slave  1      FRAME_Q holds an unaccepted frame
//   FRAME_RDY  slave  -> master 1      consumer accepts FRAME_Q when FRAME_VLD=1
// -----------------------------------------------------------------------------
interface s2p_frame_shifter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] FRAME_Q;
  logic             FRAME_VLD;
  logic             FRAME_RDY;

  modport master (
    output FRAME_Q,
    output FRAME_VLD,
    input  FRAME_RDY
  );

  modport slave (
    input  FRAME_Q,
    input  FRAME_VLD,
    output FRAME_RDY
  );
endinterface

// File: rtl/s2p_frame_shifter.sv
// -----------------------------------------------------------------------------
// s2p_frame_shifter
//   Multi-lane shift register and frame assembler sitting between the serial
//   line front-end and the parallel datapath. Each PUSH shifts LANES bits from
//   S_IN into Q and LANES bits out on S_OUT. Every WIDTH/LANES pushes complete
//   a frame, which is captured into FRAME_Q and offered downstream through a
//   VLD/RDY handshake. A frame completing while the previous one is still
//   pending is dropped and flagged on the sticky OVF output.
//
// Parameters
//   WIDTH  register/frame width; WIDTH % LANES == 0 and WIDTH/LANES >= 2
//   LANES  bits shifted per PUSH; 1 <= LANES < WIDTH
//
// Ports
//   CLK    in   1       rising-edge clock
//   RST_N  in   1       asynchronous active-low reset
//   ENB    in   1       1 = execute MODO this cycle; 0 = hold Q, S_OUT, counter
//   MODO   in   2       00 HOLD, 01 PUSH, 10 CYCLE, 11 LOAD
//   DIR    in   1       0 = toward MSB, 1 = toward LSB
//   D      in   WIDTH   parallel load data
//   S_IN   in   LANES   serial input bits
//   frm    master       FRAME_Q / FRAME_VLD out, FRAME_RDY in
//   Q      out  WIDTH   shift register contents
//   S_OUT  out  LANES   bits shifted out on the last PUSH; 0 otherwise
//   OVF    out  1       sticky: a completed frame was dropped
// -----------------------------------------------------------------------------
module s2p_frame_shifter #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   ENB,
  input  logic [1:0]             MODO,
  input  logic                   DIR,
  input  logic [WIDTH-1:0]       D,
  input  logic [LANES-1:0]       S_IN,
  s2p_frame_shifter_if.master    frm,
  output logic [WIDTH-1:0]       Q,
  output logic [LANES-1:0]       S_OUT,
  output logic                   OVF
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_PUSH  = 2'b01,
    MODE_CYCLE = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Shift helpers. DIR=0 moves data toward the MSB (new bits enter at the LSB
  // end), DIR=1 moves data toward the LSB (new bits enter at the MSB end).
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] v,
    input logic [LANES-1:0] s,
    input logic             dir
  );
    if (!dir) return {v[WIDTH-LANES-1:0], s};
    else      return {s, v[WIDTH-1:LANES]};
  endfunction

  function automatic logic [LANES-1:0] shift_out(
    input logic [WIDTH-1:0] v,
    input logic             dir
  );
    if (!dir) return v[WIDTH-1 -: LANES];
    else      return v[LANES-1:0];
  endfunction

  // A rotate is a shift whose input lanes are the lanes falling off the end.
  function automatic logic [WIDTH-1:0] rotate(
    input logic [WIDTH-1:0] v,
    input logic             dir
  );
    return shift_in(v, shift_out(v, dir), dir);
  endfunction

  // Registered state (stage p1)
  logic [WIDTH-1:0] q_p1;
  logic [LANES-1:0] s_out_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [WIDTH-1:0] frame_q_p1;
  logic             vld_p1;
  logic             ovf_p1;

  // Next-state decode (stage p0)
  mode_e            mode_p0;
  logic [WIDTH-1:0] q_p0;
  logic [LANES-1:0] s_out_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             frame_done_p0;
  logic             load_p0;
  logic             accept_p0;
  logic [WIDTH-1:0] frame_q_p0;
  logic             vld_p0;
  logic             ovf_p0;

  assign mode_p0 = mode_e'(MODO);

  // ---------------------------------------------------------------------------
  // Stage p0: shift register, S_OUT and beat counter next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_p0          = q_p1;
    s_out_p0      = s_out_p1;
    cnt_p0        = cnt_p1;
    frame_done_p0 = 1'b0;
    load_p0       = 1'b0;

    if (ENB) begin
      unique case (mode_p0)
        MODE_HOLD: begin
          s_out_p0 = '0;
        end
        MODE_PUSH: begin
          s_out_p0 = shift_out(q_p1, DIR);
          q_p0     = shift_in(q_p1, S_IN, DIR);
          // The counter is direction-agnostic: any PUSH is one beat.
          if (cnt_p1 == LAST_BEAT) begin
            cnt_p0        = '0;
            frame_done_p0 = 1'b1;
          end else begin
            cnt_p0 = cnt_p1 + CNT_W'(1);
          end
        end
        MODE_CYCLE: begin
          s_out_p0 = '0;
          q_p0     = rotate(q_p1, DIR);
        end
        MODE_LOAD: begin
          s_out_p0 = '0;
          q_p0     = D;
          cnt_p0   = '0;
          load_p0  = 1'b1;
        end
        default: begin
          s_out_p0 = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: frame handshake. Runs every cycle regardless of ENB. A frame
  // completing in the same cycle the pending one is accepted takes its place
  // without a VLD bubble; a frame completing while the pending one is stalled
  // is dropped. LOAD clears OVF even if an overflow happens the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept_p0  = vld_p1 & frm.FRAME_RDY;
    frame_q_p0 = frame_q_p1;
    vld_p0     = vld_p1 & ~accept_p0;
    ovf_p0     = ovf_p1;

    if (frame_done_p0) begin
      if (!vld_p1 || accept_p0) begin
        // The captured frame is the post-shift register value.
        frame_q_p0 = q_p0;
        vld_p0     = 1'b1;
      end else begin
        ovf_p0 = 1'b1;
      end
    end

    if (load_p0) begin
      ovf_p0 = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: state registers. Reset discards partial and pending frames.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_p1       <= '0;
      s_out_p1   <= '0;
      cnt_p1     <= '0;
      frame_q_p1 <= '0;
      vld_p1     <= 1'b0;
      ovf_p1     <= 1'b0;
    end else begin
      q_p1       <= q_p0;
      s_out_p1   <= s_out_p0;
      cnt_p1     <= cnt_p0;
      frame_q_p1 <= frame_q_p0;
      vld_p1     <= vld_p0;
      ovf_p1     <= ovf_p0;
    end
  end

  assign Q             = q_p1;
  assign S_OUT         = s_out_p1;
  assign OVF           = ovf_p1;
  assign frm.FRAME_Q   = frame_q_p1;
  assign frm.FRAME_VLD = vld_p1;

endmodule

// File: tb/tb_s2p_frame_shifter.sv
// -----------------------------------------------------------------------------
// tb_s2p_frame_shifter
//   Two instances share stimulus: dut2 (WIDTH=8, LANES=2) and dut1 (WIDTH=8,
//   LANES=1, fed S_IN[0]). A behavioural model tracks both with plain integer
//   arithmetic and a beat count per frame.
// -----------------------------------------------------------------------------
module tb_s2p_frame_shifter;

  logic       CLK;
  logic       RST_N;
  logic       ENB;
  logic [1:0] MODO;
  logic       DIR;
  logic [7:0] D;
  logic [1:0] S_IN;
  logic       rdy;

  logic [7:0] Q2, Q1;
  logic [1:0] SO2;
  logic       SO1;
  logic       OVF2, OVF1;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0 = LANES 2, index 1 = LANES 1
  int m_q[2], m_sout[2], m_beats[2], m_fq[2], m_vld[2], m_ovf[2];

  s2p_frame_shifter_if #(.WIDTH(8)) frm2 ();
  s2p_frame_shifter_if #(.WIDTH(8)) frm1 ();

  assign frm2.FRAME_RDY = rdy;
  assign frm1.FRAME_RDY = rdy;

  s2p_frame_shifter #(.WIDTH(8), .LANES(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .MODO(MODO), .DIR(DIR), .D(D),
    .S_IN(S_IN), .frm(frm2), .Q(Q2), .S_OUT(SO2), .OVF(OVF2)
  );

  s2p_frame_shifter #(.WIDTH(8), .LANES(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .MODO(MODO), .DIR(DIR), .D(D),
    .S_IN(S_IN[0]), .frm(frm1), .Q(Q1), .S_OUT(SO1), .OVF(OVF1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_sout[i] = 0; m_beats[i] = 0;
      m_fq[i] = 0; m_vld[i] = 0; m_ovf[i] = 0;
    end
  endfunction

  function automatic void model_step(input int i, input int e, input int m,
                                     input int dr, input int d, input int s,
                                     input int r);
    int L, lm, nb, sin;
    bit done, ldc, acc;
    L   = (i == 0) ? 2 : 1;
    lm  = (1 << L) - 1;
    nb  = 8 / L;
    sin = s & lm;
    done = 0; ldc = 0;
    acc = (m_vld[i] != 0) && (r != 0);
    if (e != 0) begin
      case (m)
        0: m_sout[i] = 0;
        1: begin
          if (dr == 0) begin
            m_sout[i] = (m_q[i] >> (8 - L)) & lm;
            m_q[i]    = ((m_q[i] << L) | sin) & 255;
          end else begin
            m_sout[i] = m_q[i] & lm;
            m_q[i]    = (m_q[i] >> L) | (sin << (8 - L));
          end
          m_beats[i]++;
          if (m_beats[i] == nb) begin
            m_beats[i] = 0;
            done = 1;
          end
        end
        2: begin
          m_sout[i] = 0;
          if (dr == 0) m_q[i] = ((m_q[i] << L) | (m_q[i] >> (8 - L))) & 255;
          else         m_q[i] = ((m_q[i] >> L) | (m_q[i] << (8 - L))) & 255;
        end
        default: begin
          m_sout[i]  = 0;
          m_q[i]     = d & 255;
          m_beats[i] = 0;
          ldc = 1;
        end
      endcase
    end
    if (done && (m_vld[i] == 0 || acc)) begin
      m_fq[i]  = m_q[i];
      m_vld[i] = 1;
    end else begin
      if (acc) m_vld[i] = 0;
      if (done) m_ovf[i] = 1;
    end
    if (ldc) m_ovf[i] = 0;
  endfunction

  // Drive one cycle of stimulus (from posedge+1) and advance the model.
  task automatic cyc(input bit e, input bit [1:0] m, input bit dr,
                     input bit [7:0] d, input bit [1:0] s, input bit r);
    ENB = e; MODO = m; DIR = dr; D = d; S_IN = s; rdy = r;
    model_step(0, e, m, dr, d, s, r);
    model_step(1, e, m, dr, d, s & 2'b01, r);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    ENB = 0; MODO = 0; DIR = 0; D = 0; S_IN = 0; rdy = 0;
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    // build a pending frame and dirty state
    cyc(1, 2'b11, 0, 8'hA5, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 2'b01, 0, 0, 2'(k), 0);
    cyc(1, 2'b01, 0, 0, 2'b11, 0);
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({Q2, SO2, frm2.FRAME_Q, frm2.FRAME_VLD, OVF2} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async_l2: got %h required 0",
               {Q2, SO2, frm2.FRAME_Q, frm2.FRAME_VLD, OVF2});
    end
    n_tests++;
    if ({Q1, SO1, frm1.FRAME_Q, frm1.FRAME_VLD, OVF1} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_async_l1: got %h required 0",
               {Q1, SO1, frm1.FRAME_Q, frm1.FRAME_VLD, OVF1});
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc(1, 2'b00, 0, 0, 0, 1);
    n_tests++;
    if (frm2.FRAME_VLD !== 1'b0 || OVF2 !== 1'b0 || Q2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: vld=%b ovf=%b q=%h required 0 0 00",
               frm2.FRAME_VLD, OVF2, Q2);
    end
  endtask

  task automatic test_frame_assembly();
    bit [1:0] sv [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    cyc(1, 2'b11, 0, 8'h00, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 2'b01, 0, 0, sv[k], 1);
      if (k < 3) begin
        n_tests++;
        if (frm2.FRAME_VLD !== 1'b0) begin
          n_fail++;
          $display("FAIL asm_vld_early beat %0d: got %b required 0", k + 1, frm2.FRAME_VLD);
        end
      end
    end
    n_tests++;
    if (Q2 !== 8'hE4 || frm2.FRAME_VLD !== 1'b1 || frm2.FRAME_Q !== 8'hE4) begin
      n_fail++;
      $display("FAIL asm_frame: q=%h vld=%b fq=%h required E4 1 E4",
               Q2, frm2.FRAME_VLD, frm2.FRAME_Q);
    end
    cyc(1, 2'b00, 0, 0, 0, 1);
    n_tests++;
    if (frm2.FRAME_VLD !== 1'b0 || frm2.FRAME_Q !== 8'hE4 || SO2 !== 2'b00) begin
      n_fail++;
      $display("FAIL asm_accept: vld=%b fq=%h so=%b required 0 E4 00",
               frm2.FRAME_VLD, frm2.FRAME_Q, SO2);
    end
  endtask

  task automatic test_shift_rotate();
    cyc(1, 2'b11, 0, 8'hA5, 0, 1);
    cyc(1, 2'b01, 1, 0, 2'b00, 1);
    n_tests++;
    if (Q2 !== 8'h29 || SO2 !== 2'b01) begin
      n_fail++;
      $display("FAIL push_lsb: q=%h so=%b required 29 01", Q2, SO2);
    end
    cyc(1, 2'b10, 0, 0, 2'b11, 1);
    n_tests++;
    if (Q2 !== 8'hA4 || SO2 !== 2'b00) begin
      n_fail++;
      $display("FAIL cycle_msb: q=%h so=%b required A4 00", Q2, SO2);
    end
  endtask

  task automatic test_overflow();
    bit [1:0] sv [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
    cyc(1, 2'b11, 0, 8'h00, 0, 0);
    for (int k = 0; k < 8; k++) cyc(1, 2'b01, 0, 0, sv[k], 0);
    n_tests++;
    if (Q2 !== 8'h1B || frm2.FRAME_Q !== 8'hE4 || frm2.FRAME_VLD !== 1'b1 || OVF2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: q=%h fq=%h vld=%b ovf=%b required 1B E4 1 1",
               Q2, frm2.FRAME_Q, frm2.FRAME_VLD, OVF2);
    end
    cyc(1, 2'b11, 0, 8'h00, 0, 0);
    n_tests++;
    if (OVF2 !== 1'b0 || frm2.FRAME_VLD !== 1'b1 || frm2.FRAME_Q !== 8'hE4) begin
      n_fail++;
      $display("FAIL ovf_load_clear: ovf=%b vld=%b fq=%h required 0 1 E4",
               OVF2, frm2.FRAME_VLD, frm2.FRAME_Q);
    end
  endtask

  task automatic test_simul_accept();
    // pending E4 from the previous test; counter was cleared by the LOAD
    cyc(1, 2'b01, 0, 0, 2'd0, 0);
    cyc(1, 2'b01, 0, 0, 2'd1, 0);
    cyc(1, 2'b01, 0, 0, 2'd2, 0);
    cyc(1, 2'b01, 0, 0, 2'd3, 1);
    n_tests++;
    if (frm2.FRAME_Q !== 8'h1B || frm2.FRAME_VLD !== 1'b1 || OVF2 !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_accept: fq=%h vld=%b ovf=%b required 1B 1 0",
               frm2.FRAME_Q, frm2.FRAME_VLD, OVF2);
    end
    cyc(1, 2'b00, 0, 0, 0, 1);
    n_tests++;
    if (frm2.FRAME_VLD !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_drain: vld=%b required 0", frm2.FRAME_VLD);
    end
  endtask

  task automatic test_enb_hold();
    cyc(1, 2'b11, 0, 8'h00, 0, 1);
    cyc(1, 2'b01, 0, 0, 2'd3, 1);
    cyc(1, 2'b01, 0, 0, 2'd2, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 2'b01, 0, 0, 2'd3, 1);
      n_tests++;
      if (Q2 !== 8'h0E || frm2.FRAME_VLD !== 1'b0) begin
        n_fail++;
        $display("FAIL enb_hold cyc %0d: q=%h vld=%b required 0E 0", k, Q2, frm2.FRAME_VLD);
      end
    end
    cyc(1, 2'b01, 0, 0, 2'd1, 1);
    n_tests++;
    if (Q2 !== 8'h39 || frm2.FRAME_VLD !== 1'b0) begin
      n_fail++;
      $display("FAIL enb_beat3: q=%h vld=%b required 39 0", Q2, frm2.FRAME_VLD);
    end
    cyc(1, 2'b01, 0, 0, 2'd0, 1);
    n_tests++;
    if (Q2 !== 8'hE4 || frm2.FRAME_VLD !== 1'b1 || frm2.FRAME_Q !== 8'hE4) begin
      n_fail++;
      $display("FAIL enb_beat4: q=%h vld=%b fq=%h required E4 1 E4",
               Q2, frm2.FRAME_VLD, frm2.FRAME_Q);
    end
  endtask

  task automatic test_lanes1();
    bit [7:0] exp_v;
    bit [1:0] s;
    exp_v = 8'h00;
    cyc(1, 2'b11, 0, 8'h00, 0, 1);
    for (int k = 0; k < 16; k++) begin
      s = 2'($urandom_range(0, 3));
      exp_v = {exp_v[6:0], s[0]};
      cyc(1, 2'b01, 0, 0, s, 1);
      n_tests++;
      if (Q1 !== exp_v || frm1.FRAME_VLD !== (k % 8 == 7)) begin
        n_fail++;
        $display("FAIL lanes1 push %0d: q=%h vld=%b required %h %b",
                 k + 1, Q1, frm1.FRAME_VLD, exp_v, (k % 8 == 7));
      end
      if (k % 8 == 7) begin
        n_tests++;
        if (frm1.FRAME_Q !== exp_v) begin
          n_fail++;
          $display("FAIL lanes1 frame %0d: got %h required %h", k / 8, frm1.FRAME_Q, exp_v);
        end
      end
    end
  endtask

  task automatic test_random();
    bit       e, dr, r;
    bit [1:0] m, s;
    bit [7:0] d;
    for (int k = 0; k < 400; k++) begin
      e  = ($urandom_range(0, 7) != 0);
      m  = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
      dr = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      s  = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 2) != 0);
      cyc(e, m, dr, d, s, r);
      n_tests++;
      if (Q2 !== 8'(m_q[0]) || SO2 !== 2'(m_sout[0]) || frm2.FRAME_Q !== 8'(m_fq[0]) ||
          frm2.FRAME_VLD !== 1'(m_vld[0]) || OVF2 !== 1'(m_ovf[0])) begin
        n_fail++;
        $display("FAIL random_l2 cyc %0d: q=%h so=%b fq=%h vld=%b ovf=%b required %h %b %h %b %b",
                 k, Q2, SO2, frm2.FRAME_Q, frm2.FRAME_VLD, OVF2,
                 8'(m_q[0]), 2'(m_sout[0]), 8'(m_fq[0]), 1'(m_vld[0]), 1'(m_ovf[0]));
      end
      n_tests++;
      if (Q1 !== 8'(m_q[1]) || SO1 !== 1'(m_sout[1]) || frm1.FRAME_Q !== 8'(m_fq[1]) ||
          frm1.FRAME_VLD !== 1'(m_vld[1]) || OVF1 !== 1'(m_ovf[1])) begin
        n_fail++;
        $display("FAIL random_l1 cyc %0d: q=%h so=%b fq=%h vld=%b ovf=%b required %h %b %h %b %b",
                 k, Q1, SO1, frm1.FRAME_Q, frm1.FRAME_VLD, OVF1,
                 8'(m_q[1]), 1'(m_sout[1]), 8'(m_fq[1]), 1'(m_vld[1]), 1'(m_ovf[1]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_assembly();
    test_shift_rotate();
    test_overflow();
    test_simul_accept();
    test_enb_hold();
    test_lanes1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
